plab4_net_router_output_ctrl: RTL and testbench



---
 rtl/plab4_net_router_output_ctrl.sv | 135 +++++++++++++
 tb/tb_plab4_net_router_output_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller for the ring router: round-robin arbiter that
// holds its winner across downstream stalls and returns one-hot grants.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   reqs        : request vector (bit 0 = prev, 1 = term, 2 = next)
//   grants      : one-hot grant, asserted only on a fire
//   out_val     : output message valid (independent of out_rdy)
//   out_rdy     : downstream ready
//   xbar_sel    : crossbar select, index of current winner (0 when idle)

module plab4_net_router_output_ctrl #(
    parameter int unsigned p_num_reqs   = 3,
    parameter int unsigned p_reset_prio = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_num_reqs-1:0]         reqs,
    output logic [p_num_reqs-1:0]         grants,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [$clog2(p_num_reqs)-1:0] xbar_sel
);

    localparam int unsigned c_w = $clog2(p_num_reqs);

    localparam logic [p_num_reqs-1:0] c_one      = 1;
    localparam logic [p_num_reqs-1:0] c_prio_rst = c_one << p_reset_prio;

    typedef enum logic {
        ARB,
        HOLD
    } mode_e;

    mode_e                  mode_q, mode_d;
    logic [p_num_reqs-1:0]  prio_q, prio_d;
    logic [c_w-1:0]         held_q, held_d;

    logic [c_w-1:0]         prio_idx;
    logic [c_w-1:0]         arb_idx;
    logic                   arb_found;
    logic [c_w-1:0]         winner;
    logic [p_num_reqs-1:0]  win_oh;
    logic                   val;
    logic                   fire;
    logic                   stall;

    // Index of the one-hot priority pointer.
    always_comb begin
        prio_idx = '0;
        for (int i = 0; i < int'(p_num_reqs); i++) begin
            if (prio_q[i]) begin
                prio_idx = c_w'(i);
            end
        end
    end

    // Circular scan of reqs starting at the priority position.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < int'(p_num_reqs); k++) begin
            int j;
            j = (int'(prio_idx) + k) % int'(p_num_reqs);
            if (!arb_found && reqs[j]) begin
                arb_found = 1'b1;
                arb_idx   = c_w'(j);
            end
        end
    end

    // In HOLD the held winner is kept even if a higher-priority
    // request appears; its validity then tracks only its own request.
    always_comb begin
        winner = (mode_q == HOLD) ? held_q : arb_idx;
        val    = (mode_q == HOLD) ? reqs[held_q] : (|reqs);
        if (reset) begin
            val = 1'b0;
        end
        win_oh = c_one << winner;
        fire   = val && out_rdy;
        stall  = val && !out_rdy;
    end

    always_comb begin
        out_val  = val;
        xbar_sel = val ? winner : '0;
        grants   = fire ? win_oh : '0;
    end

    always_comb begin
        mode_d = mode_q;
        prio_d = prio_q;
        held_d = held_q;
        if (fire) begin
            // Next priority is the position just above the winner.
            prio_d = {win_oh[p_num_reqs-2:0], win_oh[p_num_reqs-1]};
            mode_d = ARB;
        end else if (stall) begin
            if (mode_q == ARB) begin
                mode_d = HOLD;
                held_d = winner;
            end
        end else begin
            // Idle or held request withdrawn: re-arbitrate next cycle.
            mode_d = ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= ARB;
            prio_q <= c_prio_rst;
            held_q <= '0;
        end else begin
            mode_q <= mode_d;
            prio_q <= prio_d;
            held_q <= held_d;
        end
    end

`ifndef SYNTHESIS
    a_grants_onehot0 : assert property (
        @(posedge clk) disable iff (reset) $onehot0(grants)
    );
    a_grants_subset : assert property (
        @(posedge clk) disable iff (reset) ((grants & ~reqs) == '0)
    );
    a_grant_fire : assert property (
        @(posedge clk) disable iff (reset)
        ((grants != '0) -> (out_val && out_rdy))
    );
`endif

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Bench for plab4_net_router_output_ctrl: directed vectors with literal
// expectations, plus a per-cycle reference model and fairness tracking.

module tb_plab4_net_router_output_ctrl;

    localparam int P_RST = 1;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] xbar_sel;

    int total_cnt;
    int pass_cnt;

    plab4_net_router_output_ctrl #(
        .p_num_reqs  (3),
        .p_reset_prio(P_RST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqs    (reqs),
        .grants  (grants),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .xbar_sel(xbar_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: priority position, hold flag, held index.
    int m_prio;
    bit m_hold;
    int m_held;
    bit m_ok;
    int waitc [3];

    initial begin
        m_prio = 0;
        m_hold = 0;
        m_held = 0;
        m_ok   = 0;
        for (int i = 0; i < 3; i++) waitc[i] = 0;
    end

    always @(negedge clk) begin
        bit         ev;
        int         ew;
        logic [2:0] eg;
        logic [1:0] es;
        ev = 0;
        ew = 0;
        if (!reset) begin
            if (m_hold) begin
                ew = m_held;
                ev = reqs[m_held];
            end else begin
                ev = |reqs;
                for (int k = 2; k >= 0; k--) begin
                    if (reqs[(m_prio + k) % 3]) ew = (m_prio + k) % 3;
                end
            end
        end
        es = ev ? 2'(ew) : 2'd0;
        eg = (ev && out_rdy) ? (3'b001 << ew) : 3'b000;

        if (m_ok) begin
            total_cnt++;
            if (grants === eg && xbar_sel === es && out_val === ev)
                pass_cnt++;
            else
                $display("FAIL model t=%0t: grants=%b sel=%0d val=%b, want grants=%b sel=%0d val=%b",
                         $time, grants, xbar_sel, out_val, eg, es, ev);

            // A continuously requesting input may see at most two
            // fires to other inputs before it is granted itself.
            for (int i = 0; i < 3; i++) begin
                if (reset || !reqs[i] || grants[i]) begin
                    waitc[i] = 0;
                end else if (grants != 3'b000) begin
                    waitc[i]++;
                    total_cnt++;
                    if (waitc[i] <= 2)
                        pass_cnt++;
                    else
                        $display("FAIL fairness t=%0t: input %0d waited %0d fires, want <= 2",
                                 $time, i, waitc[i]);
                end
            end
        end

        if (reset) begin
            m_prio = P_RST;
            m_hold = 0;
            m_held = 0;
            m_ok   = 1;
        end else if (ev && out_rdy) begin
            m_prio = (ew + 1) % 3;
            m_hold = 0;
        end else if (ev) begin
            if (!m_hold) begin
                m_hold = 1;
                m_held = ew;
            end
        end else begin
            m_hold = 0;
        end
    end

    task automatic drive(input logic [2:0] r, input logic rdy,
                         input logic rst);
        @(posedge clk);
        #1;
        reqs    = r;
        out_rdy = rdy;
        reset   = rst;
    endtask

    task automatic step(input logic [2:0] r, input logic rdy,
                        input logic rst, input logic [2:0] eg,
                        input logic [1:0] es, input logic ev,
                        input string nm);
        drive(r, rdy, rst);
        @(negedge clk);
        total_cnt++;
        if (grants === eg && xbar_sel === es && out_val === ev)
            pass_cnt++;
        else
            $display("FAIL %s: grants=%b sel=%0d val=%b, want grants=%b sel=%0d val=%b",
                     nm, grants, xbar_sel, out_val, eg, es, ev);
    endtask

    initial begin
        logic [2:0] r;
        logic       rdy;
        total_cnt = 0;
        pass_cnt  = 0;
        reset     = 1'b1;
        reqs      = 3'b000;
        out_rdy   = 1'b0;

        step(3'b000, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, "reset");
        step(3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, "idle");

        step(3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, "rr0");
        step(3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, "rr1");
        step(3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, "rr2");

        for (int i = 0; i < 4; i++)
            step(3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, "single");

        step(3'b001, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, "prio_set");

        for (int i = 0; i < 3; i++)
            step(3'b011, 1'b0, 1'b0, 3'b000, 2'd1, 1'b1, "stall");
        step(3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, "stall_fire");
        step(3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, "after_fire");

        step(3'b100, 1'b0, 1'b0, 3'b000, 2'd2, 1'b1, "hold2");
        step(3'b001, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, "withdraw");
        step(3'b001, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, "after_withdraw");

        step(3'b001, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, "hold0");
        step(3'b111, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, "reset_mid_hold");
        step(3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, "after_reset");

        // Requests toggle rarely so that persistent requesters occur.
        r = 3'b000;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
            end
            rdy = ($urandom_range(0, 9) < 6);
            drive(r, rdy, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
